// File: rtl/seq_detect_ctrl.sv
// Programmable serial pattern detector with config handshake,
// overlap control and a match limit that ends the scan.
module seq_detect_ctrl #(
  parameter int MAXLEN = 8,
  parameter int LENW   = 4,
  parameter int CNTW   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [MAXLEN-1:0] cfg_pattern,
  input  logic [LENW-1:0]   cfg_len,
  input  logic              cfg_overlap,
  input  logic [CNTW-1:0]   cfg_limit,
  input  logic              start,
  input  logic              abort,
  input  logic              x,
  input  logic              x_valid,
  output logic              z,
  output logic [CNTW-1:0]   match_count,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE,
    LOADED,
    RUN,
    DONE
  } state_t;

  state_t state, state_n;

  logic [MAXLEN-1:0] pat, pat_n;
  logic [MAXLEN-1:0] hist, hist_n;
  logic [MAXLEN-1:0] mask, shifted;
  logic [LENW-1:0]   len, len_n, len_c;
  logic [LENW-1:0]   fill, fill_n, fill_inc;
  logic [CNTW-1:0]   lim, lim_n;
  logic [CNTW-1:0]   cnt, cnt_n, cnt_inc;
  logic              ovl, ovl_n;
  logic              z_n, hs, hit;

  assign cfg_ready   = (state != RUN);
  assign busy        = (state == RUN);
  assign done        = (state == DONE);
  assign match_count = cnt;
  assign hs          = cfg_valid & cfg_ready;

  always_comb begin
    mask = '0;
    for (int i = 0; i < MAXLEN; i++)
      mask[i] = (i < int'(len));
  end

  always_comb begin
    len_c = cfg_len;
    if (cfg_len == '0)
      len_c = LENW'(1);
    else if (cfg_len > LENW'(MAXLEN))
      len_c = LENW'(MAXLEN);
  end

  assign shifted  = {hist[MAXLEN-2:0], x};
  assign fill_inc = (fill < len) ? fill + LENW'(1) : len;
  assign cnt_inc  = (&cnt) ? cnt : cnt + CNTW'(1);
  assign hit      = (fill_inc == len) &&
                    (((shifted ^ pat) & mask) == '0);

  always_comb begin
    state_n = state;
    pat_n   = pat;
    len_n   = len;
    ovl_n   = ovl;
    lim_n   = lim;
    hist_n  = hist;
    fill_n  = fill;
    cnt_n   = cnt;
    z_n     = 1'b0;
    if (hs) begin
      pat_n = cfg_pattern;
      len_n = len_c;
      ovl_n = cfg_overlap;
      lim_n = cfg_limit;
    end
    case (state)
      IDLE: begin
        if (hs) state_n = LOADED;
      end
      LOADED, DONE: begin
        if (abort || hs) begin
          state_n = LOADED;
        end else if (start) begin
          state_n = RUN;
          hist_n  = '0;
          fill_n  = '0;
          cnt_n   = '0;
        end
      end
      RUN: begin
        if (abort) begin
          state_n = LOADED;
        end else if (x_valid) begin
          hist_n = shifted;
          fill_n = fill_inc;
          if (hit) begin
            z_n   = 1'b1;
            cnt_n = cnt_inc;
            if (!ovl) fill_n = '0;
            // limit reached: z and done rise on the same edge
            if (lim != '0 && cnt_inc == lim)
              state_n = DONE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      pat   <= '0;
      len   <= '0;
      ovl   <= 1'b0;
      lim   <= '0;
      hist  <= '0;
      fill  <= '0;
      cnt   <= '0;
      z     <= 1'b0;
    end else begin
      state <= state_n;
      pat   <= pat_n;
      len   <= len_n;
      ovl   <= ovl_n;
      lim   <= lim_n;
      hist  <= hist_n;
      fill  <= fill_n;
      cnt   <= cnt_n;
      z     <= z_n;
    end
  end

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Directed bench for seq_detect_ctrl: overlap, limit, gaps,
// length clamp, handshake priority and async reset.
module tb_seq_detect_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       cfg_valid = 1'b0;
  logic       cfg_ready;
  logic [7:0] cfg_pattern = '0;
  logic [3:0] cfg_len = '0;
  logic       cfg_overlap = 1'b0;
  logic [7:0] cfg_limit = '0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       x = 1'b0;
  logic       x_valid = 1'b0;
  logic       z;
  logic [7:0] match_count;
  logic       busy;
  logic       done;

  int total = 0;
  int bad = 0;

  seq_detect_ctrl #(.MAXLEN(8), .LENW(4), .CNTW(8)) dut (
    .clk(clk), .reset(reset),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .cfg_limit(cfg_limit),
    .start(start), .abort(abort),
    .x(x), .x_valid(x_valid),
    .z(z), .match_count(match_count),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic configure(input logic [7:0] p,
                           input logic [3:0] l,
                           input logic o,
                           input logic [7:0] lm);
    cfg_valid   = 1'b1;
    cfg_pattern = p;
    cfg_len     = l;
    cfg_overlap = o;
    cfg_limit   = lm;
    step();
    cfg_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic do_abort();
    abort = 1'b1;
    step();
    abort = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    x       = b;
    x_valid = 1'b1;
    step();
    x_valid = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    total++;
    if ({z, busy, done, cfg_ready} !== 4'b0001) begin
      bad++;
      $display("FAIL reset_flags got=%b exp=0001",
               {z, busy, done, cfg_ready});
    end
    total++;
    if (match_count !== 8'd0) begin
      bad++;
      $display("FAIL reset_count got=%0d exp=0", match_count);
    end
    #5 reset = 1'b1;
    step();
  endtask

  task automatic test_overlap();
    logic [4:0] bits;
    logic [4:0] zexp;
    bits = 5'b10101;
    zexp = 5'b00101;
    configure(8'b101, 4'd3, 1'b1, 8'd0);
    do_start();
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL ovl_busy got=%b exp=1", busy);
    end
    for (int i = 4; i >= 0; i--) begin
      send_bit(bits[i]);
      total++;
      if (z !== zexp[i]) begin
        bad++;
        $display("FAIL ovl_z bit%0d got=%b exp=%b",
                 4 - i, z, zexp[i]);
      end
    end
    total++;
    if (match_count !== 8'd2 || busy !== 1'b1) begin
      bad++;
      $display("FAIL ovl_end cnt=%0d busy=%b exp=2,1",
               match_count, busy);
    end
    start = 1'b1;
    step();
    start = 1'b0;
    total++;
    if (match_count !== 8'd2 || busy !== 1'b1) begin
      bad++;
      $display("FAIL run_start cnt=%0d busy=%b exp=2,1",
               match_count, busy);
    end
  endtask

  task automatic test_no_overlap();
    logic [4:0] bits;
    logic [4:0] zexp;
    bits = 5'b10101;
    zexp = 5'b00100;
    do_abort();
    configure(8'b101, 4'd3, 1'b0, 8'd0);
    do_start();
    for (int i = 4; i >= 0; i--) begin
      send_bit(bits[i]);
      total++;
      if (z !== zexp[i]) begin
        bad++;
        $display("FAIL novl_z bit%0d got=%b exp=%b",
                 4 - i, z, zexp[i]);
      end
    end
    total++;
    if (match_count !== 8'd1) begin
      bad++;
      $display("FAIL novl_cnt got=%0d exp=1", match_count);
    end
  endtask

  task automatic test_limit();
    logic [4:0] bits;
    logic [4:0] zexp;
    bits = 5'b10101;
    zexp = 5'b00101;
    do_abort();
    configure(8'b101, 4'd3, 1'b1, 8'd2);
    do_start();
    for (int i = 4; i >= 0; i--) begin
      send_bit(bits[i]);
      total++;
      if (z !== zexp[i]) begin
        bad++;
        $display("FAIL lim_z bit%0d got=%b exp=%b",
                 4 - i, z, zexp[i]);
      end
    end
    total++;
    if ({done, busy} !== 2'b10 || match_count !== 8'd2) begin
      bad++;
      $display("FAIL lim_done done=%b busy=%b cnt=%0d exp=1,0,2",
               done, busy, match_count);
    end
    for (int i = 2; i >= 0; i--) begin
      send_bit(bits[i]);
      total++;
      if (z !== 1'b0 || done !== 1'b1) begin
        bad++;
        $display("FAIL lim_hold z=%b done=%b exp=0,1", z, done);
      end
    end
    total++;
    if (match_count !== 8'd2) begin
      bad++;
      $display("FAIL lim_cnt got=%0d exp=2", match_count);
    end
    do_start();
    total++;
    if ({busy, done} !== 2'b10 || match_count !== 8'd0) begin
      bad++;
      $display("FAIL lim_restart busy=%b done=%b cnt=%0d exp=1,0,0",
               busy, done, match_count);
    end
  endtask

  task automatic test_hs_priority();
    do_abort();
    cfg_valid   = 1'b1;
    cfg_pattern = 8'b11;
    cfg_len     = 4'd2;
    cfg_overlap = 1'b1;
    cfg_limit   = 8'd0;
    start       = 1'b1;
    step();
    cfg_valid = 1'b0;
    start     = 1'b0;
    total++;
    if (busy !== 1'b0 || cfg_ready !== 1'b1) begin
      bad++;
      $display("FAIL hs_prio busy=%b rdy=%b exp=0,1",
               busy, cfg_ready);
    end
  endtask

  task automatic test_gap();
    configure(8'b101, 4'd3, 1'b1, 8'd0);
    do_start();
    send_bit(1'b1);
    send_bit(1'b0);
    for (int i = 0; i < 5; i++) begin
      step();
      total++;
      if (z !== 1'b0) begin
        bad++;
        $display("FAIL gap_idle cyc%0d got=%b exp=0", i, z);
      end
    end
    send_bit(1'b1);
    total++;
    if (z !== 1'b1 || match_count !== 8'd1) begin
      bad++;
      $display("FAIL gap_match z=%b cnt=%0d exp=1,1",
               z, match_count);
    end
    send_bit(1'b0);
    abort   = 1'b1;
    x       = 1'b1;
    x_valid = 1'b1;
    step();
    abort   = 1'b0;
    x_valid = 1'b0;
    total++;
    if (z !== 1'b0 || busy !== 1'b0 || match_count !== 8'd1) begin
      bad++;
      $display("FAIL abort z=%b busy=%b cnt=%0d exp=0,0,1",
               z, busy, match_count);
    end
    do_start();
    send_bit(1'b1);
    total++;
    if (z !== 1'b0 || match_count !== 8'd0) begin
      bad++;
      $display("FAIL abort_clr z=%b cnt=%0d exp=0,0",
               z, match_count);
    end
  endtask

  task automatic test_len_clamp();
    logic [7:0] a5;
    a5 = 8'hA5;
    do_abort();
    configure(8'h01, 4'd0, 1'b1, 8'd0);
    do_start();
    send_bit(1'b0);
    total++;
    if (z !== 1'b0) begin
      bad++;
      $display("FAIL len0_z0 got=%b exp=0", z);
    end
    send_bit(1'b1);
    total++;
    if (z !== 1'b1 || match_count !== 8'd1) begin
      bad++;
      $display("FAIL len0_z1 z=%b cnt=%0d exp=1,1", z, match_count);
    end
    do_abort();
    configure(8'hA5, 4'd15, 1'b1, 8'd0);
    do_start();
    for (int i = 7; i >= 0; i--) begin
      send_bit(a5[i]);
      total++;
      if (z !== (i == 0)) begin
        bad++;
        $display("FAIL len15_z bit%0d got=%b exp=%b",
                 7 - i, z, (i == 0));
      end
    end
  endtask

  task automatic test_async_reset();
    #2 reset = 1'b0;
    #1;
    total++;
    if ({z, busy, done, cfg_ready} !== 4'b0001 ||
        match_count !== 8'd0) begin
      bad++;
      $display("FAIL async_rst flags=%b cnt=%0d exp=0001,0",
               {z, busy, done, cfg_ready}, match_count);
    end
    #4 reset = 1'b1;
    step();
    do_start();
    total++;
    if (busy !== 1'b0 || cfg_ready !== 1'b1) begin
      bad++;
      $display("FAIL idle_start busy=%b rdy=%b exp=0,1",
               busy, cfg_ready);
    end
    send_bit(1'b1);
    total++;
    if (z !== 1'b0 || match_count !== 8'd0) begin
      bad++;
      $display("FAIL idle_x z=%b cnt=%0d exp=0,0", z, match_count);
    end
  endtask

  initial begin
    test_reset();
    test_overlap();
    test_no_overlap();
    test_limit();
    test_hs_priority();
    test_gap();
    test_len_clamp();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_detect_ctrl.md
Name: seq_detect_ctrl

Overview:
- Programmable serial pattern-detector controller that replaces fixed-pattern Moore detectors with one configurable engine.
- Accepts a pattern, length, overlap mode and match limit over a valid/ready config handshake.
- Arms on start and scans a qualified serial bit stream, pulsing z per match and counting matches.
- Sits between the control/register side and the serial input path; downstream logic consumes z, match_count and done.

Parameters:
MAXLEN, 8, maximum pattern length in bits (2..16)
LENW, 4, width of cfg_len; must hold MAXLEN
CNTW, 8, width of match counter and limit

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
cfg_valid  input  1  config offered
cfg_ready  output  1  config accepted when cfg_valid&cfg_ready at clk edge
cfg_pattern  input  MAXLEN  pattern; bit [len-1] is the first bit received, bit 0 is the last
cfg_len  input  LENW  pattern length
cfg_overlap  input  1  1 = overlapping matches allowed
cfg_limit  input  CNTW  matches before done; 0 = unlimited
start  input  1  arm/restart scan
abort  input  1  stop scan, keep config
x  input  1  serial data bit
x_valid  input  1  x qualifier
z  output  1  registered one-cycle match pulse
match_count  output  CNTW  matches since last start
busy  output  1  high in RUN
done  output  1  high in DONE

Behaviour:
- Reset (reset=0, async): state=IDLE; z=0, match_count=0, busy=0, done=0, cfg_ready=1; history, fill and config registers cleared.
- States:
  - IDLE, LOADED, RUN, DONE.
  - cfg_ready=1 in IDLE, LOADED, DONE; 0 in RUN.
- Config handshake (IDLE/LOADED/DONE):
  - Latch pattern/len/overlap/limit; next state LOADED; done cleared.
  - Length clamp: cfg_len=0 latched as 1; cfg_len>MAXLEN latched as MAXLEN.
- Starting a scan:
  - LOADED or DONE with start=1 (and no handshake that cycle) -> RUN.
  - Entering RUN clears history, fill and match_count.
  - A same-cycle handshake wins over start: the handshake is taken and start is ignored.
- RUN, per edge with x_valid=1:
  - Shift: history <= {history[MAXLEN-2:0], x}.
  - fill <= min(fill+1, len).
  - Match = (fill_next==len) and history_next[len-1:0]==pattern[len-1:0].
- On match:
  - z=1 for the following cycle.
  - match_count += 1, saturating at all-ones.
  - If overlap=0, fill <= 0, so the next match needs len fresh bits.
- Match limit: if limit!=0 and match_count_next==limit, go to DONE on the same edge; z pulse and done rise together.
- x_valid=0 cycles: no shift, no match, z=0. Gaps do not break a partial pattern.
- z is never asserted outside the cycle after a matching edge, and max one cycle per sampled bit.
- abort (LOADED/RUN/DONE) -> LOADED; z cleared next cycle; match_count retained; done cleared.
- abort has priority over x_valid and start in the same cycle.
- start while in RUN is ignored.
- DONE:
  - Holds match_count; x ignored.
  - done=1 until start, abort or a config handshake.
- Latency: last pattern bit sampled at edge N -> z high during cycle N..N+1; match_count updated at edge N.
- Reset asserted mid-scan returns to IDLE immediately, config lost.

Test Plan:
- Config pattern=3'b101, len=3, overlap=1, limit=0; start; stream 1,0,1,0,1 -> z pulses after bits 3 and 5; match_count=2; busy stays 1.
- Same stream with overlap=0 -> single z after bit 3; bit 5 does not match; match_count=1.
- pattern=101, limit=2, overlap=1; stream 10101 -> done=1 and busy=0 on the edge of bit 5, with z high in the same cycle; further 101 yields no z; start -> RUN, count=0.
- Stream 1,0 then x_valid=0 for 5 cycles, then 1 -> z after the final 1. Separately: abort after bits 1,0, then start, then 1 -> no z (history cleared).
- cfg_len=0 with pattern bit0=1, then stream 0,1 -> z after the 1 only. cfg_len=15 (MAXLEN=8) behaves as len 8: 8-bit pattern 8'hA5 detected after 8 bits.
- Reset driven low mid-RUN between edges -> outputs 0 and cfg_ready=1 immediately; after release, start without config has no effect (stays IDLE).
